bin_to_bcd_seg: RTL and testbench

//   Iterative (shift-add-3) binary-to-BCD converter with per-digit 7-segment encode.

---
 rtl/bcd_seg_pkg.sv | 49 ++++
 rtl/seg7_encode.sv | 26 ++
 rtl/bin_to_bcd_seg.sv | 180 ++++++++++++++++++
 tb/tb_bin_to_bcd_seg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the binary-to-BCD 7-segment converter.
// Holds the FSM state type, segment codes and elaboration-time helpers.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Segment order {a,b,c,d,e,f,g}, a in the MSB, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // True when the largest representable input fits in the given digit count.
    function automatic bit bcd_fits(input int width, input int digits, input bit onehot);
        logic [63:0] max_val;
        int          needed;
        max_val = onehot ? 64'(width - 1) : ((64'd1 << width) - 64'd1);
        needed  = 1;
        while (max_val >= 64'd10) begin
            needed++;
            max_val = max_val / 64'd10;
        end
        return needed <= digits;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes go dark.
module seg7_encode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_to_bcd_seg.sv
// Iterative shift-add-3 binary-to-BCD converter with per-digit 7-segment
// encoding, optional one-hot input, leading-zero blanking and valid/ready on both sides.
module bin_to_bcd_seg
    import bcd_seg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int ONEHOT   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [7*DIGITS-1:0]   out_seg,
    output logic                  out_err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = clog2(WIDTH + 1);

    if (!bcd_fits(WIDTH, DIGITS, ONEHOT != 0)) begin : g_bad_params
        $error("bin_to_bcd_seg: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               err_q, err_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic [SEG_W-1:0]   out_seg_q, out_seg_d;
    logic               out_err_q, out_err_d;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   oh_index;
    int                 oh_count;
    logic [WIDTH-1:0]   load_value;
    logic               load_err;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   result_bcd;
    logic [SEG_W-1:0]   raw_seg;
    logic [SEG_W-1:0]   result_seg;
    logic [DIGITS-1:0]  lit;
    logic               seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            sr_q      <= '0;
            err_q     <= 1'b0;
            out_bcd_q <= '0;
            out_seg_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sr_q      <= sr_d;
            err_q     <= err_d;
            out_bcd_q <= out_bcd_d;
            out_seg_q <= out_seg_d;
            out_err_q <= out_err_d;
        end
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == CONV) && (step_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CONV;
            CONV:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One-hot mode converts the position of the single set bit; anything else is an error.
    always_comb begin
        oh_index = '0;
        oh_count = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data[i]) begin
                oh_index = WIDTH'(i);
                oh_count = oh_count + 1;
            end
        end
        if (ONEHOT != 0) begin
            load_err   = (oh_count != 1);
            load_value = load_err ? '0 : oh_index;
        end else begin
            load_err   = 1'b0;
            load_value = in_data;
        end
    end

    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[WIDTH + 4*k +: 4] >= 4'd5) begin
                sr_adj[WIDTH + 4*k +: 4] = sr_q[WIDTH + 4*k +: 4] + 4'd3;
            end
        end
        sr_shift = sr_adj << 1;
    end

    assign result_bcd = err_q ? '0 : sr_shift[SR_W-1 -: BCD_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_encode u_seg7 (
            .bcd (result_bcd[4*g +: 4]),
            .seg (raw_seg[7*g +: 7])
        );
    end

    // Walk from the top digit down; a digit stays lit once any nonzero digit has been seen.
    always_comb begin
        seen       = 1'b0;
        lit        = '0;
        result_seg = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen   = seen || (result_bcd[4*k +: 4] != 4'd0);
            lit[k] = (BLANK_LZ == 0) || seen || (k == 0);
        end
        for (int k = 0; k < DIGITS; k++) begin
            result_seg[7*k +: 7] = lit[k] ? raw_seg[7*k +: 7] : SEG_BLANK;
        end
        if (err_q) begin
            result_seg = '0;
        end
    end

    always_comb begin
        step_d    = step_q;
        sr_d      = sr_q;
        err_d     = err_q;
        out_bcd_d = out_bcd_q;
        out_seg_d = out_seg_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d   = {{BCD_W{1'b0}}, load_value};
                    step_d = '0;
                    err_d  = load_err;
                end
            end
            CONV: begin
                sr_d   = sr_shift;
                step_d = step_q + CNT_W'(1);
                if (last_step) begin
                    out_bcd_d = result_bcd;
                    out_seg_d = result_seg;
                    out_err_d = err_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign out_bcd = out_bcd_q;
    assign out_seg = out_seg_q;
    assign out_err = out_err_q;

endmodule

// File: tb/tb_bin_to_bcd_seg.sv
// Scoreboard bench for bin_to_bcd_seg: three instances (binary, one-hot, no blanking)
// checked against a decimal-arithmetic reference model by an independent monitor.
module tb_bin_to_bcd_seg;

    typedef struct {
        logic [19:0] bcd;
        logic [34:0] seg;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic [15:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [19:0] out_bcd   [3];
    logic [34:0] out_seg   [3];
    logic        out_err   [3];

    exp_t        sb_q [3][$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          rand_ready = 0;
    bit          prev_valid [3];
    logic [19:0] hold_bcd [3];
    logic [34:0] hold_seg [3];
    logic [6:0]  seg_table [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                    7'b1111111, 7'b1111011};

    bin_to_bcd_seg #(.WIDTH(16), .DIGITS(5), .ONEHOT(0), .BLANK_LZ(1)) u_bin (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(out_bcd[0]), .out_seg(out_seg[0]), .out_err(out_err[0]));

    bin_to_bcd_seg #(.WIDTH(16), .DIGITS(5), .ONEHOT(1), .BLANK_LZ(1)) u_onehot (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(out_bcd[1]), .out_seg(out_seg[1]), .out_err(out_err[1]));

    bin_to_bcd_seg #(.WIDTH(16), .DIGITS(5), .ONEHOT(0), .BLANK_LZ(0)) u_noblank (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bcd(out_bcd[2]), .out_seg(out_seg[2]), .out_err(out_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by division, segments by table lookup, blanking by the top nonzero digit.
    function automatic exp_t model(input logic [15:0] data, input bit onehot, input bit blank);
        exp_t        e;
        int unsigned v;
        int unsigned pw;
        int unsigned d [5];
        int          msd;
        e.bcd = '0;
        e.seg = '0;
        e.err = 1'b0;
        e.acc = 0;
        v = 0;
        if (onehot) begin
            if ($countones(data) != 1) begin
                e.err = 1'b1;
                return e;
            end
            for (int i = 0; i < 16; i++) if (data[i]) v = i;
        end else begin
            v = data;
        end
        msd = 0;
        pw  = 1;
        for (int k = 0; k < 5; k++) begin
            d[k] = (v / pw) % 10;
            e.bcd[4*k +: 4] = 4'(d[k]);
            if (d[k] != 0) msd = k;
            pw = pw * 10;
        end
        for (int k = 0; k < 5; k++) begin
            e.seg[7*k +: 7] = (!blank || k <= msd) ? seg_table[d[k]] : 7'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic applyStimulus(input int s, input logic [15:0] data, output int acc);
        int   budget;
        exp_t e;
        in_data[s]  = data;
        in_valid[s] = 1'b1;
        budget      = 0;
        while (!in_ready[s] && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready[s]) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL dut%0d_accept_timeout: got in_ready=0, expected 1 within 200 cycles", s);
            acc = -1;
        end else begin
            acc   = cyc;
            e     = model(data, s == 1, s != 2);
            e.acc = cyc;
            sb_q[s].push_back(e);
        end
        @(negedge clk);
        in_valid[s] = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0",
                     sb_q[0].size() + sb_q[1].size() + sb_q[2].size());
        end
        @(negedge clk);
    endtask

    // Monitor: latency on each rising out_valid, stability while held, result compare on take.
    always @(negedge clk) begin
        exp_t e;
        #2;
        for (int s = 0; s < 3; s++) begin
            if (rst) begin
                prev_valid[s] = 1'b0;
            end else if (out_valid[s]) begin
                checkOutput($sformatf("dut%0d_in_ready_in_done", s), 64'(in_ready[s]), 64'd0);
                if (!prev_valid[s]) begin
                    if (sb_q[s].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("[TB] FAIL dut%0d_unexpected_output: got out_valid=1, expected no result", s);
                    end else begin
                        checkOutput($sformatf("dut%0d_latency", s), 64'(cyc - sb_q[s][0].acc), 64'd17);
                    end
                end else begin
                    checkOutput($sformatf("dut%0d_hold_bcd", s), 64'(out_bcd[s]), 64'(hold_bcd[s]));
                    checkOutput($sformatf("dut%0d_hold_seg", s), 64'(out_seg[s]), 64'(hold_seg[s]));
                end
                hold_bcd[s] = out_bcd[s];
                hold_seg[s] = out_seg[s];
                if (out_ready[s] && sb_q[s].size() != 0) begin
                    e = sb_q[s].pop_front();
                    checkOutput($sformatf("dut%0d_bcd", s), 64'(out_bcd[s]), 64'(e.bcd));
                    checkOutput($sformatf("dut%0d_seg", s), 64'(out_seg[s]), 64'(e.seg));
                    checkOutput($sformatf("dut%0d_err", s), 64'(out_err[s]), 64'(e.err));
                end
                prev_valid[s] = 1'b1;
            end else begin
                prev_valid[s] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rand_ready) begin
            for (int s = 0; s < 3; s++) out_ready[s] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int acc_a;
        int acc_b;
        int r;
        int budget;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = '0;
            out_ready[s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("dut%0d_reset_in_ready", s), 64'(in_ready[s]), 64'd1);
            checkOutput($sformatf("dut%0d_reset_out_valid", s), 64'(out_valid[s]), 64'd0);
            checkOutput($sformatf("dut%0d_reset_bcd", s), 64'(out_bcd[s]), 64'd0);
            checkOutput($sformatf("dut%0d_reset_seg", s), 64'(out_seg[s]), 64'd0);
            checkOutput($sformatf("dut%0d_reset_err", s), 64'(out_err[s]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed binary conversions");
        applyStimulus(0, 16'd12345, acc_a);
        waitDrain();
        applyStimulus(0, 16'd65535, acc_a);
        applyStimulus(0, 16'd0, acc_b);
        checkOutput("accept_spacing", 64'(acc_b - acc_a), 64'd18);
        waitDrain();

        $display("[TB] directed one-hot and no-blank conversions");
        applyStimulus(1, 16'h8000, acc_a);
        applyStimulus(2, 16'd7, acc_b);
        waitDrain();
        applyStimulus(1, 16'h0000, acc_a);
        waitDrain();
        applyStimulus(1, 16'h0003, acc_a);
        waitDrain();

        $display("[TB] backpressure");
        out_ready[0] = 1'b0;
        applyStimulus(0, 16'd999, acc_a);
        budget = 0;
        while (!out_valid[0] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("bp_out_valid_seen", 64'(out_valid[0]), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("bp_out_valid_held", 64'(out_valid[0]), 64'd1);
        out_ready[0] = 1'b1;
        waitDrain();

        $display("[TB] randomized traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 16'($urandom), acc_a);
            r = $urandom_range(0, 15);
            applyStimulus(1, ($urandom_range(0, 3) != 0) ? (16'd1 << r) : 16'($urandom), acc_a);
            applyStimulus(2, 16'($urandom_range(0, 65535)), acc_a);
        end
        @(negedge clk);
        rand_ready = 1'b0;
        for (int s = 0; s < 3; s++) out_ready[s] = 1'b1;
        waitDrain();

        $display("[TB] reset during conversion");
        applyStimulus(0, 16'd5000, acc_a);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("midrst_seg", 64'(out_seg[0]), 64'd0);
        checkOutput("midrst_bcd", 64'(out_bcd[0]), 64'd0);
        for (int s = 0; s < 3; s++) sb_q[s].delete();
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, 16'd42, acc_a);
        waitDrain();
        repeat (3) @(negedge clk);
        checkOutput("hold_after_take", 64'(out_bcd[0]), 64'h00042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
